// File: rtl/ip_sdram_sim_pkg.sv
// Shared types and default parameters for the SDRAM behavioural model.
package ip_sdram_sim_pkg;
  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_REFRESH} state_e;

  localparam int DEF_DATA_W         = 32;
  localparam int DEF_ADDR_W         = 21;
  localparam int DEF_READ_LATENCY   = 4;
  localparam int DEF_INIT_CYCLES    = 100;
  localparam int DEF_REFRESH_CYCLES = 6;
endpackage

// File: rtl/ip_sdram_sim_if.sv
// Command/response bus of the SDRAM model; the model sits on the slave side.
interface ip_sdram_sim_if
  import ip_sdram_sim_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic                  sdram_init_busy;
  logic [ADDR_W-1:0]     bus_address;
  logic                  bus_valid;
  logic                  bus_ready;
  logic                  bus_write;
  logic                  bus_refresh;
  logic [DATA_W-1:0]     bus_wdata;
  logic [DATA_W/8-1:0]   bus_wdata_mask;
  logic [DATA_W-1:0]     bus_rdata;
  logic                  bus_rdata_en;

  modport slave (
    output sdram_init_busy, bus_ready, bus_rdata, bus_rdata_en,
    input  bus_address, bus_valid, bus_write, bus_refresh, bus_wdata, bus_wdata_mask
  );
  modport master (
    input  sdram_init_busy, bus_ready, bus_rdata, bus_rdata_en,
    output bus_address, bus_valid, bus_write, bus_refresh, bus_wdata, bus_wdata_mask
  );
endinterface

// File: rtl/ip_sdram_rd_pipe.sv
// Fixed-latency read response pipeline; the last data stage holds its value between strobes.
module ip_sdram_rd_pipe
  import ip_sdram_sim_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int LAT    = DEF_READ_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);
  logic [LAT-1:0]             vld_pipe_q, vld_pipe_d;
  logic [LAT-1:0][DATA_W-1:0] data_pipe_q, data_pipe_d;
  logic [LAT:0]               vld_in;
  logic [LAT:0][DATA_W-1:0]   data_in;

  assign vld_in  = {vld_pipe_q, in_vld};
  assign data_in = {data_pipe_q, in_data};

  always_comb begin
    vld_pipe_d  = vld_in[LAT-1:0];
    data_pipe_d = data_in[LAT-1:0];
    if (!vld_in[LAT-1]) data_pipe_d[LAT-1] = data_pipe_q[LAT-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe_q  <= '0;
      data_pipe_q <= '0;
    end else begin
      vld_pipe_q  <= vld_pipe_d;
      data_pipe_q <= data_pipe_d;
    end
  end

  assign out_vld  = vld_pipe_q[LAT-1];
  assign out_data = data_pipe_q[LAT-1];
endmodule

// File: rtl/ip_sdram_sim.sv
// Behavioural SDRAM: init/refresh stall FSM, byte-masked word memory, fixed-latency reads.
module ip_sdram_sim
  import ip_sdram_sim_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int ADDR_W         = DEF_ADDR_W,
  parameter int READ_LATENCY   = DEF_READ_LATENCY,
  parameter int INIT_CYCLES    = DEF_INIT_CYCLES,
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
  input  logic            clk,
  input  logic            reset,
  ip_sdram_sim_if.slave   bus
);
  localparam int NBYTES = DATA_W / 8;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        acc, acc_ref, acc_wr, acc_rd;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // ready_q mirrors "state is IDLE", so it doubles as the accept qualifier
  assign acc     = bus.bus_valid && ready_q;
  assign acc_ref = acc && bus.bus_refresh;
  assign acc_wr  = acc && !bus.bus_refresh && bus.bus_write;
  assign acc_rd  = acc && !bus.bus_refresh && !bus.bus_write;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT:    if (cnt_q <= 32'd1) state_d = ST_IDLE; else cnt_d = cnt_q - 32'd1;
      ST_IDLE:    if (acc_ref) begin
                    state_d = ST_REFRESH;
                    cnt_d   = 32'(REFRESH_CYCLES);
                  end
      ST_REFRESH: if (cnt_q <= 32'd1) state_d = ST_IDLE; else cnt_d = cnt_q - 32'd1;
      default:    state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d == ST_INIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= (INIT_CYCLES == 0) ? ST_IDLE : ST_INIT;
      cnt_q   <= 32'(INIT_CYCLES);
      ready_q <= 1'b0;
      busy_q  <= (INIT_CYCLES != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  // Contents survive reset; no command can be accepted while reset holds ready low
  always_ff @(posedge clk) begin
    if (acc_wr) begin
      for (int b = 0; b < NBYTES; b++)
        if (!bus.bus_wdata_mask[b]) mem[bus.bus_address][b*8 +: 8] <= bus.bus_wdata[b*8 +: 8];
    end
  end

  ip_sdram_rd_pipe #(.DATA_W(DATA_W), .LAT(READ_LATENCY)) u_rd_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (acc_rd),
    .in_data  (mem[bus.bus_address]),
    .out_vld  (bus.bus_rdata_en),
    .out_data (bus.bus_rdata)
  );

  assign bus.bus_ready       = ready_q;
  assign bus.sdram_init_busy = busy_q;
endmodule
